// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard and forwarding controller for the 5-stage MIPS
// pipeline. It compares the operands of the instruction in D with the
// producers in E, M and W. From that it derives one stall/flush signal and
// the forwarding selects for the D-stage compare/jr path and the E-stage ALU.
// It also owns the busy counter of the multi-cycle mult/div unit and a
// saturating count of stall cycles.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        rs_d,
  input  logic [4:0]        rt_d,
  input  logic              cal_r_d,
  input  logic              cal_i_d,
  input  logic              ld_d,
  input  logic              st_d,
  input  logic              branch_d,
  input  logic              jr_d,
  input  logic              md_d,
  input  logic              mdread_d,
  input  logic [4:0]        rs_e,
  input  logic [4:0]        rt_e,
  input  logic [4:0]        write_reg_e,
  input  logic              reg_write_e,
  input  logic              ld_e,
  input  logic              jal_e,
  input  logic              md_e,
  input  logic              md_div_e,
  input  logic [4:0]        write_reg_m,
  input  logic              reg_write_m,
  input  logic              ld_m,
  input  logic [4:0]        write_reg_w,
  input  logic              reg_write_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_cnt
);

  // Register $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  logic [CNT_W-1:0]  md_cnt_q;
  logic [CNT_W-1:0]  md_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] stall_cnt_d;

  logic rsReadD;
  logic rtReadD;
  logic stallLoadUse;
  logic stallBranch;
  logic stallMd;
  logic stall;

  // Decode which source registers the instruction in D actually reads.
  always_comb begin
    rsReadD = cal_r_d | cal_i_d | ld_d | st_d | branch_d | jr_d | md_d;
    rtReadD = cal_r_d | st_d | branch_d | md_d;
  end

  // The three stall sources. A load in E cannot forward in time for any reader
  // in D. Branches and jr resolve in D, so they also wait for ALU results in E
  // (jal's PC+8 is the exception, it forwards straight from E) and for loads
  // in M. Any MD-unit access waits while the unit is busy.
  always_comb begin
    stallLoadUse = ld_e & reg_write_e &
                   ((rsReadD & regMatch(rs_d, write_reg_e)) |
                    (rtReadD & regMatch(rt_d, write_reg_e)));

    stallBranch  = (reg_write_e & ~jal_e &
                    (((branch_d | jr_d) & regMatch(rs_d, write_reg_e)) |
                     (branch_d & regMatch(rt_d, write_reg_e)))) |
                   (reg_write_m & ld_m &
                    (((branch_d | jr_d) & regMatch(rs_d, write_reg_m)) |
                     (branch_d & regMatch(rt_d, write_reg_m))));

    stallMd      = (md_d | mdread_d) & md_busy;

    stall        = stallLoadUse | stallBranch | stallMd;
    stall_f      = stall;
    stall_d      = stall;
    flush_e      = stall;
  end

  // D-stage forwarding for the branch comparator and the jr target.
  // Priority is youngest producer first: jal in E, then non-load in M, then W.
  always_comb begin
    fwd_rs_d = 2'b00;
    if (jal_e & reg_write_e & regMatch(rs_d, write_reg_e)) begin
      fwd_rs_d = 2'b11;
    end else if (reg_write_m & ~ld_m & regMatch(rs_d, write_reg_m)) begin
      fwd_rs_d = 2'b01;
    end else if (reg_write_w & regMatch(rs_d, write_reg_w)) begin
      fwd_rs_d = 2'b10;
    end

    fwd_rt_d = 2'b00;
    if (jal_e & reg_write_e & regMatch(rt_d, write_reg_e)) begin
      fwd_rt_d = 2'b11;
    end else if (reg_write_m & ~ld_m & regMatch(rt_d, write_reg_m)) begin
      fwd_rt_d = 2'b01;
    end else if (reg_write_w & regMatch(rt_d, write_reg_w)) begin
      fwd_rt_d = 2'b10;
    end
  end

  // E-stage ALU operand forwarding. M has priority over W because it holds the
  // more recent value of the register.
  always_comb begin
    fwd_rs_e = 2'b00;
    if (reg_write_m & ~ld_m & regMatch(rs_e, write_reg_m)) begin
      fwd_rs_e = 2'b01;
    end else if (reg_write_w & regMatch(rs_e, write_reg_w)) begin
      fwd_rs_e = 2'b10;
    end

    fwd_rt_e = 2'b00;
    if (reg_write_m & ~ld_m & regMatch(rt_e, write_reg_m)) begin
      fwd_rt_e = 2'b01;
    end else if (reg_write_w & regMatch(rt_e, write_reg_w)) begin
      fwd_rt_e = 2'b10;
    end
  end

  // MD busy counter next state. A new op in E always reloads, even if the
  // unit is somehow still counting down.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_e) begin
      md_cnt_d = md_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CNT_W'(1);
    end
    md_busy = md_e | (md_cnt_q != '0);
  end

  // Stall statistics: count stalled cycles, holding at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
    stall_cnt = stall_cnt_q;
  end

  // State registers. Reset clears both counters immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed testbench for hazard_ctrl with hand-computed
// expected values. The stall counter is narrowed to 4 bits so that
// saturation can be reached quickly.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_d, rt_d;
  logic       cal_r_d, cal_i_d, ld_d, st_d, branch_d, jr_d, md_d, mdread_d;
  logic [4:0] rs_e, rt_e, write_reg_e;
  logic       reg_write_e, ld_e, jal_e, md_e, md_div_e;
  logic [4:0] write_reg_m;
  logic       reg_write_m, ld_m;
  logic [4:0] write_reg_w;
  logic       reg_write_w;
  logic       stall_f, stall_d, flush_e;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       md_busy;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4),
    .STAT_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .cal_r_d    (cal_r_d),
    .cal_i_d    (cal_i_d),
    .ld_d       (ld_d),
    .st_d       (st_d),
    .branch_d   (branch_d),
    .jr_d       (jr_d),
    .md_d       (md_d),
    .mdread_d   (mdread_d),
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e),
    .ld_e       (ld_e),
    .jal_e      (jal_e),
    .md_e       (md_e),
    .md_div_e   (md_div_e),
    .write_reg_m(write_reg_m),
    .reg_write_m(reg_write_m),
    .ld_m       (ld_m),
    .write_reg_w(write_reg_w),
    .reg_write_w(reg_write_w),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_e    (flush_e),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  // Free-running clock, 20 time units per cycle.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance the given number of rising edges with the current inputs held,
  // then settle 2 units past the edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  // Put bubbles in every stage.
  task automatic clearInputs();
    rs_d = 0; rt_d = 0;
    cal_r_d = 0; cal_i_d = 0; ld_d = 0; st_d = 0;
    branch_d = 0; jr_d = 0; md_d = 0; mdread_d = 0;
    rs_e = 0; rt_e = 0; write_reg_e = 0;
    reg_write_e = 0; ld_e = 0; jal_e = 0; md_e = 0; md_div_e = 0;
    write_reg_m = 0; reg_write_m = 0; ld_m = 0;
    write_reg_w = 0; reg_write_w = 0;
  endtask

  // Clear inputs, then wait for the falling edge so that the next
  // combinational step starts away from any rising edge.
  task automatic newStep();
    clearInputs();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    applyStimulus(1);
    checkOutput("reset_md_busy", 16'(md_busy), 16'd0);
    checkOutput("reset_stall_cnt", 16'(stall_cnt), 16'd0);
    checkOutput("reset_stall_f", 16'(stall_f), 16'd0);
    reset = 1'b0;

    // Load-use: lw $8 in E, add rs=$8 in D.
    newStep();
    ld_e = 1; reg_write_e = 1; write_reg_e = 8; cal_r_d = 1; rs_d = 8;
    #1;
    checkOutput("lu_stall_f", 16'(stall_f), 16'd1);
    checkOutput("lu_stall_d", 16'(stall_d), 16'd1);
    checkOutput("lu_flush_e", 16'(flush_e), 16'd1);
    applyStimulus(1);
    checkOutput("lu_stall_cnt", 16'(stall_cnt), 16'd1);

    // Next cycle: lw has moved to M, bubble in E, so no more stall.
    newStep();
    ld_m = 1; reg_write_m = 1; write_reg_m = 8; cal_r_d = 1; rs_d = 8;
    #1;
    checkOutput("lu_released", 16'(stall_f), 16'd0);

    // lw now in W, add in E: forward W result.
    newStep();
    reg_write_w = 1; write_reg_w = 8; rs_e = 8;
    #1;
    checkOutput("lu_fwd_rs_e", 16'(fwd_rs_e), 16'b10);

    // An I-type ALU op does not read rt, so rt matching a load is harmless.
    newStep();
    ld_e = 1; reg_write_e = 1; write_reg_e = 8; cal_i_d = 1; rs_d = 3; rt_d = 8;
    #1;
    checkOutput("cal_i_rt_no_stall", 16'(stall_f), 16'd0);

    // Branch after an ALU op: addu $9 in E, beq rs=$9 in D.
    newStep();
    reg_write_e = 1; write_reg_e = 9; branch_d = 1; rs_d = 9;
    #1;
    checkOutput("br_e_stall", 16'(stall_d), 16'd1);

    // The addu has moved to M: no stall, forward from M.
    newStep();
    reg_write_m = 1; write_reg_m = 9; branch_d = 1; rs_d = 9;
    #1;
    checkOutput("br_m_no_stall", 16'(stall_d), 16'd0);
    checkOutput("br_fwd_rs_d", 16'(fwd_rs_d), 16'b01);

    // lw $9 in M with the beq in D: stall one more cycle.
    newStep();
    reg_write_m = 1; ld_m = 1; write_reg_m = 9; branch_d = 1; rs_d = 9;
    #1;
    checkOutput("br_ld_m_stall", 16'(flush_e), 16'd1);

    // A branch also depends on rt.
    newStep();
    reg_write_e = 1; write_reg_e = 9; branch_d = 1; rs_d = 0; rt_d = 9;
    #1;
    checkOutput("br_rt_stall", 16'(stall_f), 16'd1);

    // jal in E writing $31, jr $31 in D: forward PC+8, no stall.
    newStep();
    jal_e = 1; reg_write_e = 1; write_reg_e = 31; jr_d = 1; rs_d = 31;
    #1;
    checkOutput("jal_no_stall", 16'(stall_f), 16'd0);
    checkOutput("jal_fwd_rs_d", 16'(fwd_rs_d), 16'b11);

    // Register $0: never forwarded, never stalls.
    newStep();
    reg_write_m = 1; write_reg_m = 0; reg_write_w = 1; write_reg_w = 0;
    ld_e = 1; reg_write_e = 1; write_reg_e = 0;
    cal_r_d = 1; rs_d = 0; rs_e = 0;
    #1;
    checkOutput("zero_no_stall", 16'(stall_f), 16'd0);
    checkOutput("zero_fwd_rs_d", 16'(fwd_rs_d), 16'b00);
    checkOutput("zero_fwd_rs_e", 16'(fwd_rs_e), 16'b00);

    // M and W both write $4: M wins.
    newStep();
    reg_write_m = 1; write_reg_m = 4; reg_write_w = 1; write_reg_w = 4;
    rs_e = 4; rt_e = 4; rt_d = 4;
    #1;
    checkOutput("prio_fwd_rs_e", 16'(fwd_rs_e), 16'b01);
    checkOutput("prio_fwd_rt_e", 16'(fwd_rt_e), 16'b01);
    checkOutput("prio_fwd_rt_d", 16'(fwd_rt_d), 16'b01);
    reg_write_m = 0;
    #1;
    checkOutput("w_fwd_rt_e", 16'(fwd_rt_e), 16'b10);
    checkOutput("w_fwd_rt_d", 16'(fwd_rt_d), 16'b10);

    // Multiply with mfhi in D; cycle 0 also has a load-use hazard, which
    // still adds only one stall cycle.
    newStep();
    md_e = 1; md_div_e = 0; mdread_d = 1;
    ld_e = 1; reg_write_e = 1; write_reg_e = 8; cal_r_d = 1; rs_d = 8;
    #1;
    checkOutput("mult_c0_busy", 16'(md_busy), 16'd1);
    checkOutput("mult_c0_stall", 16'(stall_f), 16'd1);
    applyStimulus(1);
    checkOutput("dual_stall_cnt", 16'(stall_cnt), 16'd2);
    md_e = 0; ld_e = 0; reg_write_e = 0; cal_r_d = 0; rs_d = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checkOutput($sformatf("mult_c%0d_busy", i), 16'(md_busy), 16'd1);
      checkOutput($sformatf("mult_c%0d_stall", i), 16'(stall_d), 16'd1);
      applyStimulus(1);
    end
    #1;
    checkOutput("mult_c6_busy", 16'(md_busy), 16'd0);
    checkOutput("mult_c6_stall", 16'(stall_d), 16'd0);
    checkOutput("mult_stall_cnt", 16'(stall_cnt), 16'd7);

    // Divide: busy for cycles 0..10, no MD access in D.
    newStep();
    md_e = 1; md_div_e = 1;
    for (int i = 0; i <= 10; i++) begin
      #1;
      checkOutput($sformatf("div_c%0d_busy", i), 16'(md_busy), 16'd1);
      applyStimulus(1);
      md_e = 0; md_div_e = 0;
    end
    #1;
    checkOutput("div_c11_busy", 16'(md_busy), 16'd0);
    checkOutput("div_stall_cnt", 16'(stall_cnt), 16'd7);

    // Saturation: 7 more stalled cycles reach 14, three more hold at 15.
    newStep();
    ld_e = 1; reg_write_e = 1; write_reg_e = 5; st_d = 1; rt_d = 5;
    applyStimulus(7);
    checkOutput("sat_cnt_14", 16'(stall_cnt), 16'd14);
    applyStimulus(3);
    checkOutput("sat_cnt_15", 16'(stall_cnt), 16'd15);

    // Reset mid-divide while the counter is at 7 with mflo pending in D.
    newStep();
    md_e = 1; md_div_e = 1;
    applyStimulus(1);
    md_e = 0; md_div_e = 0;
    applyStimulus(3);
    mdread_d = 1;
    #1;
    checkOutput("mid_div_stall", 16'(stall_f), 16'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 16'(md_busy), 16'd0);
    checkOutput("rst_mid_stall_cnt", 16'(stall_cnt), 16'd0);
    checkOutput("rst_mid_stall", 16'(stall_f), 16'd0);
    md_e = 1;
    #1;
    checkOutput("rst_busy_follows_md_e", 16'(md_busy), 16'd1);
    md_e = 0;
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_busy", 16'(md_busy), 16'd0);
    checkOutput("post_rst_stall", 16'(stall_f), 16'd0);
    checkOutput("post_rst_stall_cnt", 16'(stall_cnt), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
